// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package regfile_dump_reader_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bundle between the dump reader, the register file's spare read port and the
// display/debug consumer. The master modport is the reader's view.
interface regfile_dump_reader_if
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_reg, last_reg, reg_data, out_ready,
    output reg_addr, out_valid, out_index, out_data, busy, done
  );

  modport slave (
    output start, first_reg, last_reg, reg_data, out_ready,
    input  reg_addr, out_valid, out_index, out_data, busy, done
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an index range through the register file's spare read port and streams
// each (index, value) pair over a valid/ready handshake, then pulses done.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic clk,
  input  logic rst,
  regfile_dump_reader_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic              valid_q;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q, done_d;

  logic load_range;
  logic capture;
  logic accept;
  logic advance;
  logic at_last;

  assign at_last = (addr_q == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_HOLD;
      ST_HOLD:  if (valid_q && bus.out_ready) state_d = at_last ? ST_FIN : ST_FETCH;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_range = (state_q == ST_IDLE) && bus.start;
    capture    = (state_q == ST_FETCH);
    accept     = (state_q == ST_HOLD) && valid_q && bus.out_ready;
    advance    = accept && !at_last;
    done_d     = (state_q == ST_FIN);
  end

  // The address only moves on range load or after an accepted entry, so reg_data
  // is settled for the whole FETCH cycle and the snapshot is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      if (load_range) begin
        addr_q <= bus.first_reg;
        last_q <= bus.last_reg;
      end else if (advance) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      if (capture) begin
        data_q  <= bus.reg_data;
        index_q <= addr_q;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      done_q <= done_d;
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.out_valid = valid_q;
  assign bus.out_index = index_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full, single, wrapped, backpressured,
// start-while-busy and mid-dump reset dumps against a small register-file array.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] rf [NUM_REGS];

  regfile_dump_reader_if bus ();

  regfile_dump_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.reg_data = rf[bus.reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    bus.first_reg = f;
    bus.last_reg  = l;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Full dump with out_ready high; cycle counts are edges after the sampling edge.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input string tag);
    logic [4:0] span;
    logic [4:0] e;
    int n_exp, k, cyc, done_at, first_v;
    span    = l - f;
    n_exp   = int'(span) + 1;
    e       = f;
    k       = 0;
    cyc     = 0;
    done_at = -1;
    first_v = -1;
    pulse_start(f, l);
    while (done_at < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        if (first_v < 0) first_v = cyc;
        $display("%s entry %0d: index=%0d data=0x%08h", tag, k, bus.out_index, bus.out_data);
        chk({tag, "_idx"}, 32'(bus.out_index), 32'(e));
        chk({tag, "_data"}, bus.out_data, rf[e]);
        e = e + 5'd1;
        k++;
      end
      if (bus.done) done_at = cyc;
    end
    chk({tag, "_count"}, 32'(k), 32'(n_exp));
    chk({tag, "_first_valid_cyc"}, 32'(first_v), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_at), 32'(2 * n_exp + 1));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  // Waits for the next entry, checks it, and leaves it consumed (out_ready high).
  task automatic expect_entry(input logic [4:0] idx, input string tag);
    int t;
    t = 0;
    while (!bus.out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    $display("%s entry: index=%0d data=0x%08h", tag, bus.out_index, bus.out_data);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_idx"}, 32'(bus.out_index), 32'(idx));
    chk({tag, "_data"}, bus.out_data, rf[idx]);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!bus.done && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    @(negedge clk);
    chk({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_cleared"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int seen_done;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.first_reg = '0;
    bus.last_reg = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'(i * 4);

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_index", 32'(bus.out_index), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_addr", 32'(bus.reg_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    run_dump(5'd0, 5'd31, "full");

    rf[5] = 32'hDEADBEEF;
    run_dump(5'd5, 5'd5, "single");

    run_dump(5'd30, 5'd1, "wrap");

    // Backpressure on the second entry while the register file rewrites it.
    pulse_start(5'd8, 5'd11);
    expect_entry(5'd8, "bp");
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_idx", 32'(bus.out_index), 32'd9);
    held = rf[9];
    chk("bp_data", bus.out_data, held);
    rf[9] = 32'h0BADF00D;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      $display("bp stall %0d: valid=%0d index=%0d data=0x%08h addr=%0d",
               c, bus.out_valid, bus.out_index, bus.out_data, bus.reg_addr);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_idx", 32'(bus.out_index), 32'd9);
      chk("bp_hold_data", bus.out_data, held);
      chk("bp_hold_addr", 32'(bus.reg_addr), 32'd9);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    expect_entry(5'd10, "bp");
    expect_entry(5'd11, "bp");
    wait_done("bp");

    // A second start mid-dump must not disturb the running range.
    pulse_start(5'd2, 5'd4);
    expect_entry(5'd2, "busy_start");
    bus.first_reg = 5'd20;
    bus.last_reg  = 5'd25;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    expect_entry(5'd3, "busy_start");
    expect_entry(5'd4, "busy_start");
    wait_done("busy_start");
    repeat (3) @(negedge clk);
    chk("busy_start_no_restart", 32'(bus.busy), 32'd0);

    // Asynchronous reset while an entry is held.
    pulse_start(5'd0, 5'd31);
    expect_entry(5'd0, "rst_mid");
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_holding", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("rst_mid: valid=%0d busy=%0d done=%0d", bus.out_valid, bus.busy, bus.done);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    chk("rst_mid_no_done", 32'(seen_done), 32'd0);

    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'hA5000000 | 32'(i);
    run_dump(5'd0, 5'd31, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
